// File: rtl/tlb_req_arbiter.sv
// tlb_req_arbiter
//   Shares one TLB lookup port between the instruction-fetch requester (if_*)
//   and the data-memory requester (mem_*). One lookup is outstanding at a time.
//   A grant pulses combinationally in the IDLE cycle that accepts a request.
//   The result comes back as a one-cycle *_rdy pulse. A flush kills an
//   accepted or in-flight lookup. If the TLB is still busy, the arbiter waits
//   in DRAIN and discards the late ack.
//
// Configuration macro:
//   TLB_ARB_RR_EN  defined   -> round-robin between requesters on contention
//                  undefined -> fixed priority, mem wins on contention
//
// Parameters:
//   VA_W   address width (virtual and physical)
//   EXC_W  TLB exception code width (0 = no exception)
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req / mem_req            translation request
//   if_vaddr / mem_vaddr        address to translate (stable while *_req)
//   if_pending_exc / mem_...    requester is ineligible this cycle
//   if_gnt / mem_gnt            one-cycle accept pulse
//   if_rdy / mem_rdy            one-cycle result-valid pulse
//   if_paddr / mem_paddr        translated address, valid with *_rdy
//   if_tlb_exc / mem_tlb_exc    exception code, valid with *_rdy
//   flush                       pipeline flush
//   tlb_req, tlb_vaddr          shared TLB lookup request
//   tlb_ack, tlb_paddr, tlb_exc TLB completion
module tlb_req_arbiter #(
  parameter int VA_W  = 32,
  parameter int EXC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [VA_W-1:0]  if_vaddr,
  input  logic             if_pending_exc,
  output logic             if_gnt,
  output logic             if_rdy,
  output logic [VA_W-1:0]  if_paddr,
  output logic [EXC_W-1:0] if_tlb_exc,
  input  logic             mem_req,
  input  logic [VA_W-1:0]  mem_vaddr,
  input  logic             mem_pending_exc,
  output logic             mem_gnt,
  output logic             mem_rdy,
  output logic [VA_W-1:0]  mem_paddr,
  output logic [EXC_W-1:0] mem_tlb_exc,
  input  logic             flush,
  output logic             tlb_req,
  output logic [VA_W-1:0]  tlb_vaddr,
  input  logic             tlb_ack,
  input  logic [VA_W-1:0]  tlb_paddr,
  input  logic [EXC_W-1:0] tlb_exc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t           state;
  logic             owner_mem;   // 1: mem owns the current lookup, 0: if
  logic [VA_W-1:0]  lat_vaddr;
  logic [VA_W-1:0]  res_paddr;
  logic [EXC_W-1:0] res_exc;

  logic elig_if;
  logic elig_mem;
  logic pick_mem;
  logic grant_any;
  logic resp_fire;

`ifdef TLB_ARB_RR_EN
  logic prio_mem;              // 1: mem wins the next contention
`endif

  // NOTE: every always_comb output gets a default before any condition so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    elig_if  = if_req  & ~if_pending_exc  & ~flush;
    elig_mem = mem_req & ~mem_pending_exc & ~flush;
    pick_mem = 1'b0;
`ifdef TLB_ARB_RR_EN
    pick_mem = elig_mem & (~elig_if | prio_mem);
`else
    pick_mem = elig_mem;
`endif
    // Grants are only possible from IDLE, so at most one lookup is in flight.
    grant_any = (state == IDLE) & ~rst & (elig_if | elig_mem);
    // A flush in RESP swallows the result pulse.
    resp_fire = (state == RESP) & ~rst & ~flush;
  end

  assign mem_gnt   = grant_any & pick_mem;
  assign if_gnt    = grant_any & ~pick_mem;
  assign mem_rdy   = resp_fire & owner_mem;
  assign if_rdy    = resp_fire & ~owner_mem;

  // The TLB keeps seeing the request through DRAIN, so the lookup it has
  // already started can finish and be thrown away cleanly.
  assign tlb_req   = ((state == LOOKUP) | (state == DRAIN)) & ~rst;
  assign tlb_vaddr = lat_vaddr;

  assign if_paddr    = res_paddr;
  assign mem_paddr   = res_paddr;
  assign if_tlb_exc  = res_exc;
  assign mem_tlb_exc = res_exc;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_mem <= 1'b0;
      lat_vaddr <= '0;
      res_paddr <= '0;
      res_exc   <= '0;
`ifdef TLB_ARB_RR_EN
      prio_mem  <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_mem <= pick_mem;
            lat_vaddr <= pick_mem ? mem_vaddr : if_vaddr;
            state     <= LOOKUP;
`ifdef TLB_ARB_RR_EN
            prio_mem  <= ~pick_mem;
`endif
          end
        end
        LOOKUP: begin
          if (tlb_ack) begin
            if (flush) begin
              state <= IDLE;
            end else begin
              res_paddr <= tlb_paddr;
              res_exc   <= tlb_exc;
              state     <= RESP;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (tlb_ack) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_req_arbiter.sv
// Directed bench for tlb_req_arbiter. Inputs change 1 ns after each rising
// edge. Outputs are sampled 2 ns later, well before the next edge. Every
// expected value is written out by hand.
module tb_tlb_req_arbiter;

  localparam int VA_W  = 32;
  localparam int EXC_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req, mem_req;
  logic [VA_W-1:0]  if_vaddr, mem_vaddr;
  logic             if_pending_exc, mem_pending_exc;
  logic             if_gnt, mem_gnt, if_rdy, mem_rdy;
  logic [VA_W-1:0]  if_paddr, mem_paddr;
  logic [EXC_W-1:0] if_tlb_exc, mem_tlb_exc;
  logic             flush;
  logic             tlb_req;
  logic [VA_W-1:0]  tlb_vaddr;
  logic             tlb_ack;
  logic [VA_W-1:0]  tlb_paddr;
  logic [EXC_W-1:0] tlb_exc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlb_req_arbiter #(.VA_W(VA_W), .EXC_W(EXC_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_req          (if_req),
    .if_vaddr        (if_vaddr),
    .if_pending_exc  (if_pending_exc),
    .if_gnt          (if_gnt),
    .if_rdy          (if_rdy),
    .if_paddr        (if_paddr),
    .if_tlb_exc      (if_tlb_exc),
    .mem_req         (mem_req),
    .mem_vaddr       (mem_vaddr),
    .mem_pending_exc (mem_pending_exc),
    .mem_gnt         (mem_gnt),
    .mem_rdy         (mem_rdy),
    .mem_paddr       (mem_paddr),
    .mem_tlb_exc     (mem_tlb_exc),
    .flush           (flush),
    .tlb_req         (tlb_req),
    .tlb_vaddr       (tlb_vaddr),
    .tlb_ack         (tlb_ack),
    .tlb_paddr       (tlb_paddr),
    .tlb_exc         (tlb_exc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  logic exp_mem;

  initial begin
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0;
    if_vaddr = '0; mem_vaddr = '0;
    if_pending_exc = 1'b0; mem_pending_exc = 1'b0;
    flush = 1'b0; tlb_ack = 1'b0; tlb_paddr = '0; tlb_exc = '0;

    // Reset: nothing is granted or requested while rst is high.
    next_cycle;
    if_req = 1'b1; if_vaddr = 32'h8000_1000;
    settle;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_mem_gnt", mem_gnt, 0);
    check("rst_tlb_req", tlb_req, 0);
    check("rst_if_rdy", if_rdy, 0);
    next_cycle;

    // Basic fetch lookup, also the first cycle after reset (cycle N).
    rst = 1'b0;
    settle;
    check("t1_if_gnt_n", if_gnt, 1);
    check("t1_mem_gnt_n", mem_gnt, 0);
    check("t1_tlb_req_n", tlb_req, 0);
    next_cycle;
    if_req = 1'b0; tlb_ack = 1'b1; tlb_paddr = 32'h0000_1000; tlb_exc = 2'd0;
    settle;
    check("t1_tlb_req_n1", tlb_req, 1);
    check("t1_tlb_vaddr", tlb_vaddr, 32'h8000_1000);
    check("t1_if_gnt_n1", if_gnt, 0);
    next_cycle;
    tlb_ack = 1'b0; tlb_paddr = '0;
    settle;
    check("t1_if_rdy_n2", if_rdy, 1);
    check("t1_if_paddr", if_paddr, 32'h0000_1000);
    check("t1_if_exc", if_tlb_exc, 0);
    check("t1_mem_rdy", mem_rdy, 0);
    next_cycle;
    settle;
    check("t1_if_rdy_n3", if_rdy, 0);
    check("t1_tlb_req_n3", tlb_req, 0);

    // A stray ack in IDLE produces nothing.
    tlb_ack = 1'b1; tlb_paddr = 32'hdead_beef;
    next_cycle;
    tlb_ack = 1'b0; tlb_paddr = '0;
    settle;
    check("stray_if_rdy", if_rdy, 0);
    check("stray_mem_rdy", mem_rdy, 0);
    check("stray_tlb_req", tlb_req, 0);
    next_cycle;

    // Contention with both requests held.
    if_req = 1'b1; mem_req = 1'b1;
    if_vaddr = 32'h0040_0000; mem_vaddr = 32'h1000_2000;
    for (int i = 0; i < 4; i++) begin
`ifdef TLB_ARB_RR_EN
      exp_mem = (i % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      settle;
      check("t2_mem_gnt", mem_gnt, exp_mem);
      check("t2_if_gnt", if_gnt, !exp_mem);
      next_cycle;
      tlb_ack = 1'b1; tlb_paddr = 32'h100 + i;
      settle;
      check("t2_tlb_vaddr", tlb_vaddr, exp_mem ? 32'h1000_2000 : 32'h0040_0000);
      next_cycle;
      tlb_ack = 1'b0; tlb_paddr = '0;
      settle;
      check("t2_mem_rdy", mem_rdy, exp_mem);
      check("t2_if_rdy", if_rdy, !exp_mem);
      check("t2_paddr", exp_mem ? mem_paddr : if_paddr, 32'h100 + i);
      check("t2_gnt_in_resp", mem_gnt | if_gnt, 0);
      next_cycle;
    end
    if_req = 1'b0; mem_req = 1'b0;

    // An ineligible mem request is skipped, and if is granted.
    mem_req = 1'b1; mem_pending_exc = 1'b1;
    settle;
    check("t3_mem_gnt_a", mem_gnt, 0);
    next_cycle;
    settle;
    check("t3_tlb_req", tlb_req, 0);
    check("t3_mem_gnt_b", mem_gnt, 0);
    if_req = 1'b1; if_vaddr = 32'h0040_0100;
    settle;
    check("t3_if_gnt", if_gnt, 1);
    check("t3_mem_gnt_c", mem_gnt, 0);
    next_cycle;
    if_req = 1'b0; mem_req = 1'b0; mem_pending_exc = 1'b0;
    tlb_ack = 1'b1; tlb_paddr = 32'h0000_0100;
    settle;
    next_cycle;
    tlb_ack = 1'b0; tlb_paddr = '0;
    settle;
    check("t3_if_rdy", if_rdy, 1);
    check("t3_if_paddr", if_paddr, 32'h0000_0100);
    next_cycle;

    // A flush in IDLE blocks the grant for that cycle.
    if_req = 1'b1; flush = 1'b1;
    settle;
    check("t4_flush_idle_gnt", if_gnt, 0);
    next_cycle;
    flush = 1'b0;
    settle;
    check("t4_no_lookup", tlb_req, 0);
    check("t4_if_gnt", if_gnt, 1);
    next_cycle;
    // A flush that coincides with the ack drops the result and returns straight to IDLE.
    if_req = 1'b0; flush = 1'b1; tlb_ack = 1'b1; tlb_paddr = 32'h0000_0bad;
    settle;
    check("t5_tlb_req", tlb_req, 1);
    next_cycle;
    flush = 1'b0; tlb_ack = 1'b0; tlb_paddr = '0;
    mem_req = 1'b1; mem_vaddr = 32'h2000_0000;
    settle;
    check("t5_if_rdy", if_rdy, 0);
    check("t5_tlb_req_idle", tlb_req, 0);
    check("t5_mem_gnt", mem_gnt, 1);
    next_cycle;
    // Flush one cycle after the grant, with the ack three cycles later.
    flush = 1'b1;
    settle;
    check("t6_tlb_req_n1", tlb_req, 1);
    check("t6_mem_gnt_n1", mem_gnt, 0);
    next_cycle;
    flush = 1'b0;
    settle;
    check("t6_tlb_req_n2", tlb_req, 1);
    check("t6_mem_gnt_n2", mem_gnt, 0);
    next_cycle;
    settle;
    check("t6_tlb_req_n3", tlb_req, 1);
    next_cycle;
    tlb_ack = 1'b1; tlb_paddr = 32'h0000_0bad;
    settle;
    check("t6_tlb_req_n4", tlb_req, 1);
    check("t6_mem_rdy_n4", mem_rdy, 0);
    next_cycle;
    tlb_ack = 1'b0; tlb_paddr = '0;
    mem_vaddr = 32'h3000_0000;
    settle;
    check("t6_mem_rdy_n5", mem_rdy, 0);
    check("t6_regrant_n5", mem_gnt, 1);
    next_cycle;
    // A mem lookup returns an exception, and pending_exc rising after the grant is ignored.
    mem_req = 1'b0; mem_pending_exc = 1'b1;
    tlb_ack = 1'b1; tlb_paddr = 32'h0003_0000; tlb_exc = 2'b01;
    settle;
    check("t7_tlb_vaddr", tlb_vaddr, 32'h3000_0000);
    next_cycle;
    tlb_ack = 1'b0; tlb_paddr = '0; tlb_exc = '0;
    settle;
    check("t7_mem_rdy", mem_rdy, 1);
    check("t7_mem_exc", mem_tlb_exc, 2'b01);
    check("t7_mem_paddr", mem_paddr, 32'h0003_0000);
    check("t7_if_rdy", if_rdy, 0);
    mem_pending_exc = 1'b0;
    next_cycle;

    // A flush in RESP suppresses rdy.
    if_req = 1'b1; if_vaddr = 32'h0040_0200;
    settle;
    check("t8_if_gnt", if_gnt, 1);
    next_cycle;
    if_req = 1'b0; tlb_ack = 1'b1; tlb_paddr = 32'h0000_0200;
    settle;
    next_cycle;
    tlb_ack = 1'b0; tlb_paddr = '0; flush = 1'b1;
    settle;
    check("t8_if_rdy_flushed", if_rdy, 0);
    next_cycle;
    flush = 1'b0;
    settle;
    check("t8_if_rdy_after", if_rdy, 0);
    check("t8_tlb_req_after", tlb_req, 0);

    // Reset during LOOKUP, with an ack in the same cycle.
    mem_req = 1'b1; mem_vaddr = 32'h4000_0000;
    settle;
    check("t9_mem_gnt", mem_gnt, 1);
    next_cycle;
    mem_req = 1'b0; rst = 1'b1;
    tlb_ack = 1'b1; tlb_paddr = 32'h0004_0000; tlb_exc = 2'b11;
    settle;
    check("t9_mem_gnt_rst", mem_gnt, 0);
    next_cycle;
    rst = 1'b0; tlb_ack = 1'b0; tlb_paddr = '0; tlb_exc = '0;
    settle;
    check("t9_tlb_req", tlb_req, 0);
    check("t9_mem_rdy", mem_rdy, 0);
    check("t9_if_rdy", if_rdy, 0);
    check("t9_mem_paddr", mem_paddr, 0);
    check("t9_mem_exc", mem_tlb_exc, 0);
    mem_req = 1'b1; mem_vaddr = 32'h5000_0000;
    settle;
    check("t9_first_gnt", mem_gnt, 1);
    next_cycle;
    mem_req = 1'b0; tlb_ack = 1'b1; tlb_paddr = 32'h0005_0000;
    settle;
    check("t9_tlb_vaddr", tlb_vaddr, 32'h5000_0000);
    next_cycle;
    tlb_ack = 1'b0; tlb_paddr = '0;
    settle;
    check("t9_mem_rdy_final", mem_rdy, 1);
    check("t9_mem_paddr_final", mem_paddr, 32'h0005_0000);
    next_cycle;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
